// File: rtl/accelerator_arbiter_pkg.sv
// rtl/accelerator_arbiter_pkg.sv - shared types and constants for the float adder arbiter
package accelerator_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int DEFAULT_TIMEOUT = 1024;

   // A single requester still needs a one-bit index so the grant/pointer signals exist.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/accelerator_round_robin_selector.sv
// rtl/accelerator_round_robin_selector.sv - rotate-priority-encode of the pending vector from the pointer
module accelerator_round_robin_selector #(
   parameter int REQUESTERS = 4,
   parameter int PTR_W      = 2
) (
   input  logic [REQUESTERS-1:0] pending,
   input  logic [PTR_W-1:0]      pointer,
   output logic [PTR_W-1:0]      grant,
   output logic                  valid
);

   logic [REQUESTERS-1:0] rotated;
   int                    offset;
   int                    index;

   // Rotate so the pointer lands on bit 0, pick the lowest set bit, then rotate the index back.
   always_comb begin
      rotated = REQUESTERS'({pending, pending} >> pointer);
      offset  = 0;
      for (int k = REQUESTERS - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset = k;
         end
      end
      index = int'(pointer) + offset;
      if (index >= REQUESTERS) begin
         index = index - REQUESTERS;
      end
      grant = PTR_W'(index);
      valid = |pending;
   end

endmodule

// File: rtl/accelerator_scalar_float_adder_arbiter.sv
// rtl/accelerator_scalar_float_adder_arbiter.sv - round-robin sharing of one float adder; optional ACCELERATOR_FLOAT_ADDER_ARBITER_TIMEOUT_EN
module accelerator_scalar_float_adder_arbiter
   import accelerator_arbiter_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64,
   parameter int REQUESTERS   = 4
`ifdef ACCELERATOR_FLOAT_ADDER_ARBITER_TIMEOUT_EN
   ,
   parameter int TIMEOUT      = DEFAULT_TIMEOUT
`endif
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [REQUESTERS-1:0]           START_IN,
   output logic [REQUESTERS-1:0]           READY_OUT,
   input  logic [REQUESTERS-1:0]           OPERATION_IN,
   input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_A_IN,
   input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_B_IN,
   output logic [DATA_SIZE-1:0]            DATA_OUT,
   output logic                            BUSY,
   output logic                            ADDER_START,
   input  logic                            ADDER_READY,
   output logic                            ADDER_OPERATION,
   output logic [DATA_SIZE-1:0]            ADDER_DATA_A_OUT,
   output logic [DATA_SIZE-1:0]            ADDER_DATA_B_OUT,
   input  logic [DATA_SIZE-1:0]            ADDER_DATA_IN
`ifdef ACCELERATOR_FLOAT_ADDER_ARBITER_TIMEOUT_EN
   ,
   output logic                            ERROR
`endif
);

   localparam int PTR_W = ptr_width(REQUESTERS);

   // Control width is carried for interface compatibility with the adder; reject nonsense sizes.
   if (REQUESTERS < 1 || DATA_SIZE < 1 || CONTROL_SIZE < 1) begin : g_bad_params
      $error("accelerator_scalar_float_adder_arbiter: sizes must be at least 1");
   end

   state_t                state;
   state_t                next_state;
   logic [REQUESTERS-1:0] pending;
   logic [REQUESTERS-1:0] accept;
   logic [REQUESTERS-1:0] grant_onehot;
   logic [REQUESTERS-1:0] release_mask;
   logic [PTR_W-1:0]      pointer;
   logic [PTR_W-1:0]      grant;
   logic [PTR_W-1:0]      sel_grant;
   logic                  sel_valid;
   logic                  respond;
   logic                  adder_done;
   logic                  timeout_hit;

   logic                  buf_op [REQUESTERS];
   logic [DATA_SIZE-1:0]  buf_a  [REQUESTERS];
   logic [DATA_SIZE-1:0]  buf_b  [REQUESTERS];

   accelerator_round_robin_selector #(
      .REQUESTERS (REQUESTERS),
      .PTR_W      (PTR_W)
   ) u_selector (
      .pending (pending),
      .pointer (pointer),
      .grant   (sel_grant),
      .valid   (sel_valid)
   );

   assign respond    = (state == RESPOND);
   assign adder_done = (state == WAIT) && ADDER_READY;

`ifdef ACCELERATOR_FLOAT_ADDER_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             timed_out;

   assign timeout_hit = (state == WAIT) && !ADDER_READY && (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Count WAIT cycles; remember whether this job is being answered because the adder went silent.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt  <= '0;
         timed_out <= 1'b0;
      end else begin
         wait_cnt  <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
         timed_out <= timeout_hit;
      end
   end

   assign ERROR = respond && timed_out;
`else
   assign timeout_hit = 1'b0;
`endif

   // Decode the registered grant once; it drives READY_OUT and the pending clear.
   always_comb begin
      grant_onehot = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         grant_onehot[i] = (grant == PTR_W'(i));
      end
   end

   // A client may be accepted when idle, or in its own RESPOND cycle where the new request wins.
   always_comb begin
      accept = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         accept[i] = START_IN[i] && (!pending[i] || (respond && grant_onehot[i]));
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-state strobes.
   always_comb begin
      next_state   = state;
      ADDER_START  = 1'b0;
      release_mask = '0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            ADDER_START = 1'b1;
            next_state  = WAIT;
         end
         WAIT: begin
            if (adder_done || timeout_hit) begin
               next_state = RESPOND;
            end
         end
         RESPOND: begin
            release_mask = grant_onehot;
            next_state   = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign READY_OUT = release_mask;
   assign BUSY      = (state != IDLE) || (|pending);

   // Pending bits: set on accept, cleared when the job is answered; a same-cycle set wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~release_mask) | accept;
      end
   end

   // Operand buffers load only on an accepted request, so duplicates cannot disturb a queued job.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < REQUESTERS; i++) begin
            buf_op[i] <= OP_ADD;
            buf_a[i]  <= '0;
            buf_b[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < REQUESTERS; i++) begin
            if (accept[i]) begin
               buf_op[i] <= OPERATION_IN[i];
               buf_a[i]  <= DATA_A_IN[i*DATA_SIZE +: DATA_SIZE];
               buf_b[i]  <= DATA_B_IN[i*DATA_SIZE +: DATA_SIZE];
            end
         end
      end
   end

   // Grant is captured when leaving IDLE; the pointer advances past the client just answered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         grant   <= '0;
         pointer <= '0;
      end else begin
         if (state == IDLE && sel_valid) begin
            grant <= sel_grant;
         end
         if (respond) begin
            pointer <= (grant == PTR_W'(REQUESTERS - 1)) ? '0 : grant + PTR_W'(1);
         end
      end
   end

   // Result register holds until the next completion; a timeout reports all ones.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA_OUT <= '0;
      end else if (adder_done) begin
         DATA_OUT <= ADDER_DATA_IN;
      end else if (timeout_hit) begin
         DATA_OUT <= '1;
      end
   end

   // The granted buffer cannot change before RESPOND, so these stay stable for the whole job.
   assign ADDER_OPERATION  = buf_op[grant];
   assign ADDER_DATA_A_OUT = buf_a[grant];
   assign ADDER_DATA_B_OUT = buf_b[grant];

endmodule
